// File: rtl/async_fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO: producer request, synced read pointer, RAM and status outputs.
// walmost_full exists only when ASYNC_FIFO_ALMOST_FULL_EN is defined.
interface async_fifo_wptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wclken;
    logic                  wfull;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    logic                  walmost_full;
`endif

    modport master (
        output wr_en, wq2_rptr, ovf_clr,
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
        input  walmost_full,
`endif
        input  wptr, waddr, wclken, wfull, wlevel, overflow
    );

    modport slave (
        input  wr_en, wq2_rptr, ovf_clr,
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
        output walmost_full,
`endif
        output wptr, waddr, wclken, wfull, wlevel, overflow
    );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// Async FIFO write-side pointer/full logic; optional almost-full via ASYNC_FIFO_ALMOST_FULL_EN.
// Latency: wptr/wfull/wlevel registered, 1 cycle after an accepted write; wclken combinational.
// Backpressure: writes while wfull are dropped (no RAM write) and set sticky overflow.
module async_fifo_wptr_full #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                clk,
    input  logic                rst,
    async_fifo_wptr_full_if.slave wif
);
    localparam int AW = ADDR_WIDTH;

    if (ADDR_WIDTH < 2) begin : g_bad_aw
        $error("ADDR_WIDTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_af
        $error("AF_THRESH out of range");
    end

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] wlevel_next;
    logic [AW:0] full_pattern;
    logic        push;
    logic        wfull_next;
    logic        overflow_next;

    assign push       = wif.wr_en & ~wif.wfull;
    assign wbin_next  = wbin + {{AW{1'b0}}, push};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray that means the top two bits differ and the rest agree.
    assign full_pattern = {~wif.wq2_rptr[AW:AW-1], wif.wq2_rptr[AW-2:0]};
    assign wfull_next   = (wgray_next == full_pattern);

    for (genvar i = 0; i <= AW; i++) begin : g_g2b
        assign rbin[i] = ^wif.wq2_rptr[AW:i];
    end

    assign wlevel_next   = wbin_next - rbin;
    assign overflow_next = (wif.wr_en & wif.wfull) | (wif.overflow & ~wif.ovf_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin         <= '0;
            wif.wptr     <= '0;
            wif.wfull    <= 1'b0;
            wif.wlevel   <= '0;
            wif.overflow <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wif.wptr     <= wgray_next;
            wif.wfull    <= wfull_next;
            wif.wlevel   <= wlevel_next;
            wif.overflow <= overflow_next;
        end
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_T = AF_THRESH[AW:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wif.walmost_full <= 1'b0;
        end else begin
            wif.walmost_full <= (wlevel_next >= AF_T);
        end
    end
`else
`endif

    assign wif.waddr  = wbin[AW-1:0];
    assign wif.wclken = push;
endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full with ADDR_WIDTH=4, AF_THRESH=12.
module tb_async_fifo_wptr_full;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    async_fifo_wptr_full_if #(.ADDR_WIDTH(4)) wif ();

    async_fifo_wptr_full #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
        .clk (clk),
        .rst (rst),
        .wif (wif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one edge; inputs may be changed immediately after return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [4:0] wb, rb, prev;

    initial begin
        wif.wr_en    = 1'b0;
        wif.wq2_rptr = '0;
        wif.ovf_clr  = 1'b0;
        do_reset();
        #1;
        check("rst_wptr",   wif.wptr,     5'd0);
        check("rst_waddr",  wif.waddr,    4'd0);
        check("rst_wfull",  wif.wfull,    1'b0);
        check("rst_wlevel", wif.wlevel,   5'd0);
        check("rst_ovf",    wif.overflow, 1'b0);
        check("rst_wclken", wif.wclken,   1'b0);

        // Fill 16 entries with the reader parked at 0.
        for (int i = 0; i < 16; i++) begin
            wif.wr_en = 1'b1;
            #1;
            check("fill_wclken", wif.wclken, 1'b1);
            check("fill_waddr",  wif.waddr,  i);
            tick();
            check("fill_wptr",   wif.wptr,   gray(5'(i + 1)));
            check("fill_wlevel", wif.wlevel, i + 1);
            check("fill_wfull",  wif.wfull,  (i == 15));
        end
        check("full_wptr", wif.wptr, 5'b11000);

        // Writes while full are dropped and raise overflow.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ovf_wclken", wif.wclken, 1'b0);
            tick();
            check("ovf_wptr", wif.wptr,     5'b11000);
            check("ovf_set",  wif.overflow, 1'b1);
        end
        wif.wr_en = 1'b0;
        tick();
        check("ovf_sticky", wif.overflow, 1'b1);
        wif.wr_en   = 1'b1;
        wif.ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", wif.overflow, 1'b1);
        wif.wr_en = 1'b0;
        tick();
        check("ovf_clr", wif.overflow, 1'b0);
        wif.ovf_clr = 1'b0;
        tick();
        check("ovf_stays_clr", wif.overflow, 1'b0);

        // One read frees a slot; one write refills it.
        wif.wq2_rptr = 5'b00001;
        tick();
        check("read_wfull",  wif.wfull,  1'b0);
        check("read_wlevel", wif.wlevel, 5'd15);
        wif.wr_en = 1'b1;
        #1;
        check("refill_wclken", wif.wclken, 1'b1);
        check("refill_waddr",  wif.waddr,  4'd0);
        tick();
        wif.wr_en = 1'b0;
        check("refill_wfull",  wif.wfull,  1'b1);
        check("refill_wlevel", wif.wlevel, 5'd16);
        check("refill_wptr",   wif.wptr,   5'b11001);

        // Wrap-around with the reader trailing: level stays 8 after each write.
        wb = 5'd17;
        rb = wb - 5'd7;
        wif.wq2_rptr = gray(rb);
        tick();
        check("wrap_pre_wfull",  wif.wfull,  1'b0);
        check("wrap_pre_wlevel", wif.wlevel, 5'd7);
        for (int i = 0; i < 40; i++) begin
            prev = wif.wptr;
            rb = wb - 5'd7;
            wif.wq2_rptr = gray(rb);
            wif.wr_en    = 1'b1;
            #1;
            check("wrap_wclken", wif.wclken, 1'b1);
            check("wrap_waddr",  wif.waddr,  wb[3:0]);
            tick();
            wb = wb + 5'd1;
            check("wrap_wptr",   wif.wptr,   gray(wb));
            check("wrap_1bit",   $countones(wif.wptr ^ prev), 1);
            check("wrap_wlevel", wif.wlevel, 5'd8);
            check("wrap_wfull",  wif.wfull,  1'b0);
        end
        wif.wr_en = 1'b0;

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
        wif.wq2_rptr = '0;
        do_reset();
        check("af_rst", wif.walmost_full, 1'b0);
        for (int i = 0; i < 12; i++) begin
            wif.wr_en = 1'b1;
            tick();
            check("af_level", wif.walmost_full, (i == 11));
        end
        wif.wr_en    = 1'b0;
        wif.wq2_rptr = gray(5'd1);
        tick();
        check("af_drop", wif.walmost_full, 1'b0);
`endif

        // Reset in the middle of a write burst.
        wif.wq2_rptr = '0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wif.wr_en = 1'b1;
            tick();
        end
        check("pre_rst_wptr", wif.wptr, gray(5'd7));
        rst = 1'b1;
        tick();
        check("mid_rst_wptr",   wif.wptr,     5'd0);
        check("mid_rst_waddr",  wif.waddr,    4'd0);
        check("mid_rst_wfull",  wif.wfull,    1'b0);
        check("mid_rst_wlevel", wif.wlevel,   5'd0);
        check("mid_rst_ovf",    wif.overflow, 1'b0);
        check("mid_rst_wclken", wif.wclken,   1'b1);
        rst = 1'b0;
        #1;
        check("post_rst_waddr", wif.waddr, 4'd0);
        tick();
        check("post_rst_wptr",   wif.wptr,   5'd1);
        check("post_rst_wlevel", wif.wlevel, 5'd1);
        check("post_rst_waddr1", wif.waddr,  4'd1);
        wif.wr_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/async_fifo_wptr_full.md
# async_fifo_wptr_full

Write-domain pointer and full-flag generator for the team's asynchronous FIFO. Sits directly upstream of the read-domain pointer synchronizer. It produces the registered Gray-coded write pointer that the synchronizer carries across domains, and the binary write address for the dual-port RAM. It also consumes the read pointer after synchronization into this domain, and uses it to drive a registered full flag, a fill level and a sticky overflow error.

## Interface
- ADDR_WIDTH, 4: RAM address width; FIFO depth = 2**ADDR_WIDTH; legal range ≥ 2.
- AF_THRESH, 12: almost-full threshold in entries, 1..2**ADDR_WIDTH; used only with ASYNC_FIFO_ALMOST_FULL_EN.

Ports:
- clk  in  1  write-domain clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request from producer.
- wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray coded, already synchronized into this domain.
- ovf_clr  in  1  clears sticky overflow.
- wptr  out  ADDR_WIDTH+1  write pointer, Gray coded, registered; goes to the read-domain synchronizer.
- waddr  out  ADDR_WIDTH  RAM write address = low bits of the binary pointer.
- wclken  out  1  RAM write enable = wr_en & ~wfull (combinational).
- wfull  out  1  FIFO full, registered.
- wlevel  out  ADDR_WIDTH+1  occupancy as seen by the write side, registered.
- overflow  out  1  sticky flag: a write was attempted while full.
- walmost_full  out  1  level ≥ AF_THRESH, registered (macro only).

## Operation
- State registers: wbin (ADDR_WIDTH+1, binary), wptr (Gray), wfull, wlevel, overflow, walmost_full.
- Accept: push = wr_en & ~wfull.
- Binary increment: wbin_next = wbin + push, modulo 2**(ADDR_WIDTH+1). Wraps naturally.
- Gray encoding: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Full detection: wfull_next = (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
- Level:
  - rbin = Gray-to-binary of wq2_rptr (XOR prefix from MSB).
  - wlevel_next = wbin_next − rbin, modulo 2**(ADDR_WIDTH+1).
  - Range is 0..2**ADDR_WIDTH.
- Overflow: set when wr_en & wfull; cleared by ovf_clr. If both occur in the same cycle, set wins.
- Empty/read progress: handled only through wq2_rptr. wfull deasserts on the first edge where wq2_rptr no longer matches the full pattern.
- Pessimism: full and level lag real reads by the synchronizer latency plus one cycle. They never under-report occupancy.

## Timing
- Reset (rst high at edge): wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, overflow=0, walmost_full=0. The reset value of wclken follows wr_en.
- waddr points at the slot for the current cycle's write; the RAM writes on the same edge at which wbin advances.
- Latency from accepted write to outputs:
  - wptr, wlevel, wfull: 1 cycle.
  - Write visible in the read domain: wptr + 2 read clocks.
- The write that fills the last slot is accepted; wfull is high on the following cycle.
- wr_en while wfull: no pointer change, no RAM write, overflow set next cycle.
- wptr changes by exactly one Gray bit per accepted write, including the wrap from 2**(ADDR_WIDTH+1)−1 to 0.
- Reset mid-operation: all state returns to reset values at that edge; in-flight request is dropped. The read side must be reset together with this block.

## Configuration
- ASYNC_FIFO_ALMOST_FULL_EN defined:
  - walmost_full port and register present.
  - walmost_full_next = (wlevel_next ≥ AF_THRESH).
- Undefined:
  - Port absent, no comparator.
  - AF_THRESH ignored.
  - All other behaviour identical.

## Test plan
- Reset, then 16 consecutive wr_en with wq2_rptr=0 (ADDR_WIDTH=4) → 16 wclken pulses at waddr 0..15; wfull=1 and wlevel=16 one cycle after 16th; wptr=5'b11000.
- Full state, wr_en=1 for 3 cycles → wclken=0, wptr holds 5'b11000, overflow=1 and stays 1 until ovf_clr pulse → 0.
- Full, then drive wq2_rptr=5'b00001 (one read) → wfull=0 and wlevel=15 the next cycle; one further write refills → wfull=1.
- Wrap-around: advance wq2_rptr along with writes through 40 writes → wptr Gray sequence has single-bit steps, and wraps from binary 31 to 0; waddr wraps 15→0; wfull never asserts while wlevel<16.
- Macro on, AF_THRESH=12: 11 writes → walmost_full=0; 12th → walmost_full=1 next cycle; read progress to level 11 → 0. Macro off → port absent, build succeeds.
- rst asserted after 7 writes with wr_en held high → all outputs reset next edge; the first write after release is at waddr 0.
